// File: rtl/muller_c_handshake_arb.sv
// Round-robin scheduler giving NREQ requesters turns at one four-phase handshake on an external C-element.
// Ack arrives 8+2*skew cycles after the grant edge with an ideal element; a hung element lands in ERR until cleared.
module muller_c_handshake_arb #(
   parameter int NREQ    = 2,
   parameter int SKEW_W  = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [NREQ-1:0]   req_i,
   output logic [NREQ-1:0]   ack_o,
   input  logic [SKEW_W-1:0] skew_i,
   input  logic              c_out_i,
   output logic              c_a_o,
   output logic              c_b_o,
   output logic              busy_o,
   output logic              err_o,
   input  logic              err_clr_i,
   output logic [CNT_W-1:0]  cycle_cnt_o
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RISE_A,
      S_WAIT_HI,
      S_FALL_A,
      S_WAIT_LO,
      S_ERR
   } state_t;

   state_t              r_state;
   logic                r_c_meta;
   logic                r_c_s;
   logic                r_a;
   logic                r_b;
   logic                r_busy;
   logic                r_err;
   logic [NREQ-1:0]     r_ack;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_gnt;
   logic [SKEW_W-1:0]   r_skew;
   logic [SKEW_W-1:0]   r_dwell;
   logic [TMR_W-1:0]    r_tmr;
   logic [CNT_W-1:0]    r_cnt;

   logic [NREQ-1:0]     w_rot;
   logic                w_found;
   logic [IDX_W-1:0]    w_win;
   logic [IDX_W-1:0]    w_ptr_nxt;

   function automatic logic [IDX_W-1:0] f_mod(input logic [IDX_W:0] v);
      logic [IDX_W:0] w_t;
      w_t = (v >= (IDX_W+1)'(NREQ)) ? v - (IDX_W+1)'(NREQ) : v;
      return w_t[IDX_W-1:0];
   endfunction

   // Rotate requests so bit 0 is the requester at the pointer, then take the first set bit.
   always_comb begin
      w_rot   = NREQ'({req_i, req_i} >> r_ptr);
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found = 1'b1;
            w_win   = f_mod({1'b0, r_ptr} + {1'b0, IDX_W'(i)});
         end
      end
      w_ptr_nxt = f_mod({1'b0, w_win} + (IDX_W+1)'(1));
   end

   // Synchronizer resets to 1 so nothing is granted until the element is seen low.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_c_meta <= 1'b1;
         r_c_s    <= 1'b1;
      end else begin
         r_c_meta <= c_out_i;
         r_c_s    <= r_c_meta;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_ack   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_skew  <= '0;
         r_dwell <= '0;
         r_tmr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found && !r_c_s) begin
                  r_gnt   <= w_win;
                  r_ptr   <= w_ptr_nxt;
                  r_skew  <= skew_i;
                  r_dwell <= '0;
                  r_a     <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_RISE_A;
               end
            end
            S_RISE_A: begin
               if (r_dwell == r_skew) begin
                  r_b     <= 1'b1;
                  r_tmr   <= '0;
                  r_state <= S_WAIT_HI;
               end else begin
                  r_dwell <= r_dwell + SKEW_W'(1);
               end
            end
            S_WAIT_HI: begin
               if (r_c_s) begin
                  r_a     <= 1'b0;
                  r_dwell <= '0;
                  r_state <= S_FALL_A;
               end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            S_FALL_A: begin
               if (r_dwell == r_skew) begin
                  r_b     <= 1'b0;
                  r_tmr   <= '0;
                  r_state <= S_WAIT_LO;
               end else begin
                  r_dwell <= r_dwell + SKEW_W'(1);
               end
            end
            S_WAIT_LO: begin
               if (!r_c_s) begin
                  r_ack   <= NREQ'(1) << r_gnt;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            S_ERR: begin
               r_a <= 1'b0;
               r_b <= 1'b0;
               if (err_clr_i) begin
                  r_err   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_a     <= 1'b0;
               r_b     <= 1'b0;
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ack_o       = r_ack;
   assign c_a_o       = r_a;
   assign c_b_o       = r_b;
   assign busy_o      = r_busy;
   assign err_o       = r_err;
   assign cycle_cnt_o = r_cnt;

endmodule

// File: tb/tb_muller_c_handshake_arb.sv
// Directed bench for muller_c_handshake_arb with an ideal C-element model and an ack scoreboard.
module tb_muller_c_handshake_arb;
   localparam int NREQ    = 2;
   localparam int SKEW_W  = 4;
   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   ack;
   logic [SKEW_W-1:0] skew;
   logic              c_out;
   logic              a;
   logic              b;
   logic              busy;
   logic              err;
   logic              err_clr;
   logic [CNT_W-1:0]  cnt;

   logic c_model   = 1'b0;
   logic force_en  = 1'b0;
   logic force_val = 1'b0;

   muller_c_handshake_arb #(
      .NREQ(NREQ), .SKEW_W(SKEW_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .ack_o(ack), .skew_i(skew),
      .c_out_i(c_out), .c_a_o(a), .c_b_o(b), .busy_o(busy), .err_o(err),
      .err_clr_i(err_clr), .cycle_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   // Ideal zero-delay C-element: follows the inputs when they agree, holds otherwise.
   always @(a or b) begin
      if (a === 1'b1 && b === 1'b1) c_model = 1'b1;
      else if (a === 1'b0 && b === 1'b0) c_model = 1'b0;
   end
   assign c_out = force_en ? force_val : c_model;

   int   cyc = 0;
   logic rst_q;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Protocol monitor: edge ordering, ack shape, and edge timestamps.
   logic pa = 1'b0, pb = 1'b0, pack = 1'b0;
   int   t_ar = -1, t_br = -1, t_af = -1, t_bf = -1;
   int   n_ack_seen = 0;
   always @(negedge clk) begin
      if (rst_q === 1'b0 && err === 1'b0) begin
         if (b === 1'b1 && pb === 1'b0) chk("b_rise_needs_a", 32'(a), 1);
         if (a !== pa || b !== pb) chk("ab_single_change", 32'((a !== pa) && (b !== pb)), 0);
      end
      if (a === 1'b1 && pa === 1'b0) t_ar = cyc;
      if (b === 1'b1 && pb === 1'b0) t_br = cyc;
      if (a === 1'b0 && pa === 1'b1) t_af = cyc;
      if (b === 1'b0 && pb === 1'b1) t_bf = cyc;
      if (ack !== '0 && ack !== 'x) begin
         n_ack_seen++;
         chk("ack_onehot", 32'($onehot(ack)), 1);
         chk("ack_one_cycle", 32'(pack), 0);
      end
      pa   = a;
      pb   = b;
      pack = (ack !== '0 && ack !== 'x);
   end

   typedef struct {
      logic [NREQ-1:0]  vec;
      int               cyc;
      logic [CNT_W-1:0] cnt;
   } exp_t;
   exp_t             sb[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int               n_ack_exp = 0;

   task automatic push_exp(input logic [NREQ-1:0] vec, input int g, input int s);
      exp_t e;
      exp_cnt   = exp_cnt + CNT_W'(1);
      e.vec     = vec;
      e.cyc     = g + 2 * s + 8;
      e.cnt     = exp_cnt;
      sb.push_back(e);
      n_ack_exp++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic await_ack(input bit drop);
      int   waited;
      exp_t e;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (ack === '0 && waited < 60);
      chk("ack_within_budget", 32'(ack !== '0), 1);
      if (ack === '0) return;
      if (drop) req = req & ~ack;
      if (sb.size() == 0) begin
         chk("ack_unexpected", 32'(ack), 0);
         return;
      end
      e = sb.pop_front();
      chk("ack_vec", 32'(ack), 32'(e.vec));
      chk("ack_cycle", cyc, e.cyc);
      chk("ack_cnt", 32'(cnt), 32'(e.cnt));
   endtask

   task automatic run_one(input logic [NREQ-1:0] vec, input int s);
      int g;
      skew = SKEW_W'(s);
      req  = vec;
      g    = cyc + 1;
      push_exp(vec, g, s);
      tick(1);
      skew = SKEW_W'($urandom);
      await_ack(1'b1);
      chk("a_rise_cycle", t_ar, g);
      chk("b_rise_cycle", t_br, g + s + 1);
      chk("a_fall_cycle", t_af, g + s + 4);
      chk("b_fall_cycle", t_bf, g + 2 * s + 5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int f;
      int waited;
      rst = 1'b1; req = '0; skew = '0; err_clr = 1'b0;
      tick(3);
      chk("rst_a", 32'(a), 0);
      chk("rst_b", 32'(b), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(cnt), 0);
      rst = 1'b0;
      tick(4);

      // Single requester, no skew.
      run_one(2'b01, 0);

      // Both requesting from reset: strict alternation starting at requester 0.
      rst = 1'b1; tick(2); rst = 1'b0; exp_cnt = '0; tick(4);
      skew = '0;
      req  = 2'b11;
      g    = cyc + 1;
      push_exp(2'b01, g, 0);
      push_exp(2'b10, g + 9, 0);
      push_exp(2'b01, g + 18, 0);
      push_exp(2'b10, g + 27, 0);
      await_ack(1'b0);
      await_ack(1'b0);
      await_ack(1'b0);
      await_ack(1'b0);
      req = '0;

      // Skew 3, latched at grant even though skew_i changes afterwards.
      run_one(2'b10, 3);

      // Element stuck low: timeout into ERR, then clear.
      force_en = 1'b1; force_val = 1'b0;
      skew = '0;
      req  = 2'b01;
      g    = cyc + 1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (err !== 1'b1 && waited < 200);
      chk("err_within_budget", 32'(err), 1);
      chk("err_cycle", cyc, g + 1 + TIMEOUT);
      chk("err_a", 32'(a), 0);
      chk("err_b", 32'(b), 0);
      chk("err_busy", 32'(busy), 1);
      tick(3);
      chk("err_no_grant", 32'(a), 0);
      chk("err_held", 32'(err), 1);
      req = '0;
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("err_cleared", 32'(err), 0);
      chk("err_clr_idle", 32'(busy), 0);
      force_en = 1'b0;
      tick(3);

      // Reset while waiting high with the element output high.
      skew = '0;
      req  = 2'b01;
      tick(3);
      chk("pre_rst_b_high", 32'(b), 1);
      force_en = 1'b1; force_val = 1'b1;
      rst = 1'b1;
      tick(1);
      chk("midrst_a", 32'(a), 0);
      chk("midrst_b", 32'(b), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_cnt", 32'(cnt), 0);
      exp_cnt = '0;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("no_grant_c_high", 32'(a), 0);
      end
      force_en = 1'b0;
      f = cyc;
      push_exp(2'b01, f + 3, 0);
      await_ack(1'b1);
      chk("post_rst_grant", t_ar, f + 3);

      // Fifteen more completions wrap the 4-bit counter to zero.
      for (int i = 0; i < 15; i++) begin
         run_one((i % 2) ? 2'b10 : 2'b01, i % 3);
      end
      chk("cnt_wrapped", 32'(cnt), 0);

      tick(5);
      chk("total_acks", n_ack_seen, n_ack_exp);
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
